// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a registered single-port data RAM.
// Master 0 (core) has fixed priority; master 1 (aux) is guaranteed a slot
// after STARVE_LIMIT consecutive blocked cycles. Read data returns one cycle
// after the grant and is steered to the master that issued the read.
module dmem_arbiter #(
   parameter int DATA_SIZE    = 32,
   parameter int ADDR_SIZE    = 10,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 CLEAR,
   input  logic                 m0_req,
   input  logic                 m0_we,
   input  logic [ADDR_SIZE-1:0] m0_addr,
   input  logic [DATA_SIZE-1:0] m0_wdata,
   output logic                 m0_gnt,
   output logic                 m0_rvalid,
   output logic [DATA_SIZE-1:0] m0_rdata,
   input  logic                 m1_req,
   input  logic                 m1_we,
   input  logic [ADDR_SIZE-1:0] m1_addr,
   input  logic [DATA_SIZE-1:0] m1_wdata,
   output logic                 m1_gnt,
   output logic                 m1_rvalid,
   output logic [DATA_SIZE-1:0] m1_rdata,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic                 mem_we,
   output logic                 mem_re,
   output logic [DATA_SIZE-1:0] mem_wdata,
   input  logic [DATA_SIZE-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] r_starve_cnt;
   logic             r_rd_pend;
   logic             r_rd_owner;

   logic w_active;
   logic w_force1;
   logic w_gnt0;
   logic w_gnt1;
   logic w_rd_gnt;

   // Grants are gated by reset so nothing reaches the RAM while reset is held.
   assign w_active = RESET_N & ~CLEAR;
   assign w_force1 = (r_starve_cnt >= LIMIT);
   assign w_gnt1   = w_active & m1_req & (w_force1 | ~m0_req);
   assign w_gnt0   = w_active & m0_req & ~w_gnt1;
   assign w_rd_gnt = (w_gnt0 & ~m0_we) | (w_gnt1 & ~m1_we);

   assign m0_gnt = w_gnt0;
   assign m1_gnt = w_gnt1;

   // CLEAR also masks a read return already in flight this cycle.
   assign m0_rvalid = r_rd_pend & ~r_rd_owner & ~CLEAR;
   assign m1_rvalid = r_rd_pend &  r_rd_owner & ~CLEAR;
   assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
   assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

   // Route the granted master onto the RAM port; idle port drives zeros.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if (w_gnt1) begin
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
         mem_we    = m1_we;
         mem_re    = ~m1_we;
      end else if (w_gnt0) begin
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
         mem_we    = m0_we;
         mem_re    = ~m0_we;
      end
   end

   // Track the outstanding read and the starvation count of master 1.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_starve_cnt <= '0;
         r_rd_pend    <= 1'b0;
         r_rd_owner   <= 1'b0;
      end else if (CLEAR) begin
         r_starve_cnt <= '0;
         r_rd_pend    <= 1'b0;
      end else begin
         r_rd_pend <= w_rd_gnt;
         if (w_rd_gnt) begin
            r_rd_owner <= w_gnt1;
         end
         if (w_gnt1) begin
            r_starve_cnt <= '0;
         end else if (m1_req && (r_starve_cnt < LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
         end
      end
   end

endmodule
